axi4_lite_cmd_sequencer: RTL and testbench
==========================================

AXI4_LITE_CMD_SEQUENCER -- requirements
Module: axi4_lite_cmd_sequencer

Interface
REQ-001 Parameter DATA_WIDTH, default 32, data path width.
REQ-002 Parameter ADDRESS, default 32, address width.
REQ-003 Parameter DEPTH, default 4, command FIFO entries (power of 2, >= 2).
REQ-004 Parameter TIMEOUT, default 255, maximum WAIT cycles before forced error completion (1..65535).
REQ-005 ACLK  in  1  single clock; all logic on its rising edge.
REQ-006 ARESETN  in  1  reset, asynchronous assert, active-low.
REQ-007 cmd_valid  in  1  command offered.
REQ-008 cmd_ready  out  1  command FIFO can accept.
REQ-009 cmd_write  in  1  1 = write command, 0 = read command.
REQ-010 cmd_addr  in  ADDRESS  command address.
REQ-011 cmd_wdata  in  DATA_WIDTH  write data (ignored for reads).
REQ-012 read_s  out  1  single-cycle read-start pulse to the AXI4-lite master top.
REQ-013 write_s  out  1  single-cycle write-start pulse to the AXI4-lite master top.
REQ-014 address  out  ADDRESS  address to the master top.
REQ-015 W_data  out  DATA_WIDTH  write data to the master top.
REQ-016 bus_bdone  in  1  BVALID&&BREADY observed on the AXI write-response channel.
REQ-017 bus_rdone  in  1  RVALID&&RREADY observed on the AXI read-data channel.
REQ-018 bus_rdata  in  DATA_WIDTH  RDATA, valid when bus_rdone=1.
REQ-019 bus_resp  in  2  BRESP when bus_bdone=1, RRESP when bus_rdone=1.
REQ-020 rsp_valid  out  1  completion available.
REQ-021 rsp_ready  in  1  consumer accepts completion.
REQ-022 rsp_write  out  1  completion type, copy of cmd_write.
REQ-023 rsp_data  out  DATA_WIDTH  read data; 0 for writes and timeouts.
REQ-024 rsp_resp  out  2  AXI response code; 2'b10 on timeout.
REQ-025 busy  out  1  high whenever state != IDLE.

Function
REQ-026 Command FIFO: push when cmd_valid&&cmd_ready; cmd_ready = !full; pointers wrap modulo DEPTH; count is 0..DEPTH.
REQ-027 A push and a pop in the same cycle leave the count unchanged; a push is never accepted while full, even if a pop occurs that cycle.
REQ-028 FSM states IDLE, ISSUE, WAIT, RESP; exactly one transaction is outstanding at any time.
REQ-029 IDLE: FIFO non-empty -> pop head, load address/W_data/type registers, go ISSUE; FIFO empty -> stay IDLE.
REQ-030 ISSUE (one cycle): write_s=1 for writes or read_s=1 for reads, never both; clear timeout counter; go WAIT.
REQ-031 address and W_data hold the popped values from ISSUE until the next IDLE pop, never changing mid-transaction.
REQ-032 WAIT, write: bus_bdone -> capture rsp_resp=bus_resp, rsp_data=0, go RESP.
REQ-033 WAIT, read: bus_rdone -> capture rsp_data=bus_rdata, rsp_resp=bus_resp, go RESP.
REQ-034 WAIT: done strobes of the other type, and all done strobes outside WAIT, are ignored.
REQ-035 WAIT: counter increments each cycle without a matching done; when it reaches TIMEOUT -> rsp_resp=2'b10, rsp_data=0, go RESP; a matching done in that same cycle takes priority.
REQ-036 RESP: rsp_valid=1 with stable rsp_* until rsp_ready; in the rsp_valid&&rsp_ready cycle -> IDLE.
REQ-037 Minimum command-to-start latency is 2 cycles from the push edge to read_s/write_s high (push, then IDLE pop, then ISSUE); back-to-back gap from handshake to next start is 2 cycles.
REQ-038 The FIFO keeps accepting commands in every state while not full.

Reset
REQ-039 ARESETN low asynchronously forces state IDLE, FIFO empty (cmd_ready=1 after release), counters 0, and read_s, write_s, rsp_valid, busy, rsp_write, rsp_resp, rsp_data, address and W_data to 0.
REQ-040 Reset mid-transaction discards the outstanding transaction and all queued commands; no rsp_valid is produced for them.

Verification
REQ-041 Write 0x0000_0010/0xDEAD_BEEF, bus_bdone with resp 00 four cycles after write_s -> exactly one write_s pulse, address/W_data stable, rsp_valid with rsp_write=1, rsp_resp=00, rsp_data=0.
REQ-042 Read 0x0000_0004, bus_rdone with rdata 0x1234_5678, resp 00 -> rsp_data=0x1234_5678, rsp_write=0, exactly one read_s pulse.
REQ-043 Push 5 commands with DEPTH=4 while the first is stalled in WAIT -> cmd_ready drops after 5 accepted (1 in flight + 4 queued); completions return in push order.
REQ-044 Read with no bus_rdone, TIMEOUT=8 -> RESP entered after 8 WAIT cycles, rsp_resp=10, rsp_data=0.
REQ-045 rsp_ready held low 10 cycles -> rsp_* stable and no new start pulse until the handshake.
REQ-046 ARESETN asserted during WAIT with 2 commands queued -> all outputs 0 immediately; after release, no rsp_valid and no start pulses without new commands.

Source files
------------

// File: rtl/axi4_lite_cmd_sequencer.sv
// Command sequencer for an AXI4-lite master: queues read/write commands, issues
// them one at a time as start pulses, and returns completions or forced timeouts.
module axi4_lite_cmd_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDRESS    = 32,
    parameter int DEPTH      = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDRESS-1:0]    cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  read_s,
    output logic                  write_s,
    output logic [ADDRESS-1:0]    address,
    output logic [DATA_WIDTH-1:0] W_data,
    input  logic                  bus_bdone,
    input  logic                  bus_rdone,
    input  logic [DATA_WIDTH-1:0] bus_rdata,
    input  logic [1:0]            bus_resp,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic [1:0]            rsp_resp,
    output logic                  busy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int TO_W  = 16;
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
    localparam logic [1:0]       RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t state_reg, state_next;

    logic [ADDRESS-1:0]    fifo_addr  [DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data  [DEPTH];
    logic                  fifo_write [DEPTH];

    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;

    logic [ADDRESS-1:0]    address_reg;
    logic [DATA_WIDTH-1:0] wdata_reg;
    logic                  type_reg;
    logic [TO_W-1:0]       to_cnt_reg;

    logic                  rsp_write_reg;
    logic [DATA_WIDTH-1:0] rsp_data_reg;
    logic [1:0]            rsp_resp_reg;

    logic fifo_push;
    logic fifo_pop;
    logic bus_match;
    logic timeout_hit;

    assign cmd_ready   = (count_reg != CNT_FULL);
    assign fifo_push   = cmd_valid && cmd_ready;
    assign fifo_pop    = (state_reg == ST_IDLE) && (count_reg != '0);
    assign bus_match   = type_reg ? bus_bdone : bus_rdone;
    assign timeout_hit = (to_cnt_reg == TO_LAST);

    // One storage slot per entry; only the slot under the write pointer loads.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            always_ff @(posedge ACLK) begin
                if (fifo_push && (wr_ptr_reg == PTR_W'(gi))) begin
                    fifo_addr[gi]  <= cmd_addr;
                    fifo_data[gi]  <= cmd_wdata;
                    fifo_write[gi] <= cmd_write;
                end
            end
        end
    endgenerate

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (fifo_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (fifo_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({fifo_push, fifo_pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (fifo_pop) begin
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                // A matching done on the last allowed cycle still wins over the timeout.
                if (bus_match || timeout_hit) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            address_reg   <= '0;
            wdata_reg     <= '0;
            type_reg      <= 1'b0;
            to_cnt_reg    <= '0;
            rsp_write_reg <= 1'b0;
            rsp_data_reg  <= '0;
            rsp_resp_reg  <= '0;
        end else begin
            if (fifo_pop) begin
                address_reg <= fifo_addr[rd_ptr_reg];
                wdata_reg   <= fifo_data[rd_ptr_reg];
                type_reg    <= fifo_write[rd_ptr_reg];
            end

            if (state_reg == ST_ISSUE) begin
                to_cnt_reg <= '0;
            end else if ((state_reg == ST_WAIT) && !bus_match) begin
                to_cnt_reg <= to_cnt_reg + TO_W'(1);
            end

            if ((state_reg == ST_WAIT) && (bus_match || timeout_hit)) begin
                rsp_write_reg <= type_reg;
                if (bus_match) begin
                    rsp_resp_reg <= bus_resp;
                    rsp_data_reg <= type_reg ? '0 : bus_rdata;
                end else begin
                    rsp_resp_reg <= RESP_SLVERR;
                    rsp_data_reg <= '0;
                end
            end
        end
    end

    assign read_s    = (state_reg == ST_ISSUE) && !type_reg;
    assign write_s   = (state_reg == ST_ISSUE) && type_reg;
    assign address   = address_reg;
    assign W_data    = wdata_reg;
    assign rsp_valid = (state_reg == ST_RESP);
    assign rsp_write = rsp_write_reg;
    assign rsp_data  = rsp_data_reg;
    assign rsp_resp  = rsp_resp_reg;
    assign busy      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_axi4_lite_cmd_sequencer.sv
// Scoreboard bench for axi4_lite_cmd_sequencer: randomized commands, a modelled
// bus slave with noise strobes, and a decoupled completion monitor.
module tb_axi4_lite_cmd_sequencer;

    localparam int DW      = 32;
    localparam int AW      = 32;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 8;

    logic          ACLK = 1'b0;
    logic          ARESETN = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          read_s;
    logic          write_s;
    logic [AW-1:0] address;
    logic [DW-1:0] W_data;
    logic          bus_bdone = 1'b0;
    logic          bus_rdone = 1'b0;
    logic [DW-1:0] bus_rdata = '0;
    logic [1:0]    bus_resp = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic          rsp_write;
    logic [DW-1:0] rsp_data;
    logic [1:0]    rsp_resp;
    logic          busy;

    always #5 ACLK = ~ACLK;

    axi4_lite_cmd_sequencer #(
        .DATA_WIDTH(DW), .ADDRESS(AW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .read_s(read_s), .write_s(write_s), .address(address), .W_data(W_data),
        .bus_bdone(bus_bdone), .bus_rdone(bus_rdone), .bus_rdata(bus_rdata),
        .bus_resp(bus_resp),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_data(rsp_data), .rsp_resp(rsp_resp), .busy(busy)
    );

    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } cmd_t;

    typedef struct {
        bit            wr;
        logic [DW-1:0] data;
        logic [1:0]    resp;
    } rsp_t;

    cmd_t cmd_q[$];   // accepted, not yet started
    rsp_t rsp_q[$];   // started, completion not yet consumed

    int checks = 0;
    int errors = 0;

    // Bus-slave controls: directed overrides are consumed by the next start.
    int            dir_k = -1;      // -1 random, 0 never answer, >0 answer in that WAIT cycle
    bit            dir_en = 0;
    logic [DW-1:0] dir_rdata = '0;
    logic [1:0]    dir_resp = '0;
    bit            noise_en = 1;
    bit            bus_active = 0;
    bit            resp_due = 0;
    int            bus_w = 0;
    int            bus_k = 0;
    cmd_t          cur;
    logic [DW-1:0] cur_rdata;
    logic [1:0]    cur_resp;

    int hold = 0;
    int hold_req = 0;
    bit have_prev = 0;
    rsp_t prev;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // FIFO occupancy model: commands accepted but not yet started.
    always @(negedge ACLK) begin
        #1;
        if (ARESETN) begin
            chk("cmd_ready_vs_occupancy", cmd_ready, (cmd_q.size() < DEPTH));
        end
    end

    // Bus slave model and start-pulse checker.
    always @(negedge ACLK) begin
        bit in_wait;
        bit drove;
        rsp_t e;
        in_wait = 0;
        drove = 0;
        bus_bdone = 1'b0;
        bus_rdone = 1'b0;
        bus_resp = 2'($urandom);
        bus_rdata = $urandom;
        if (ARESETN) begin
            if (resp_due) begin
                chk("rsp_valid_after_wait", rsp_valid, 1'b1);
                resp_due = 0;
            end
            if (read_s || write_s) begin
                chk("start_not_both", read_s & write_s, 1'b0);
                chk("start_allowed", (!bus_active && rsp_q.size() == 0 && cmd_q.size() != 0), 1'b1);
                if (!bus_active && cmd_q.size() != 0) begin
                    cur = cmd_q.pop_front();
                    chk("start_kind", write_s, cur.wr);
                    chk("start_addr", address, cur.addr);
                    if (cur.wr) chk("start_wdata", W_data, cur.data);
                    if (dir_k >= 0) begin
                        bus_k = dir_k;
                        dir_k = -1;
                    end else begin
                        bus_k = ($urandom % 5 == 0) ? 0 : int'($urandom_range(1, TIMEOUT));
                    end
                    if (dir_en) begin
                        cur_rdata = dir_rdata;
                        cur_resp = dir_resp;
                        dir_en = 0;
                    end else begin
                        cur_rdata = $urandom;
                        cur_resp = 2'($urandom);
                    end
                    e.wr = cur.wr;
                    e.data = (bus_k == 0 || cur.wr) ? '0 : cur_rdata;
                    e.resp = (bus_k == 0) ? 2'b10 : cur_resp;
                    rsp_q.push_back(e);
                    bus_active = 1;
                    bus_w = 0;
                end
            end else if (bus_active) begin
                bus_w++;
                in_wait = 1;
                chk("addr_stable", address, cur.addr);
                if (cur.wr) chk("wdata_stable", W_data, cur.data);
                chk("no_rsp_during_wait", rsp_valid, 1'b0);
                if (bus_w == bus_k) begin
                    if (cur.wr) bus_bdone = 1'b1;
                    else bus_rdone = 1'b1;
                    bus_resp = cur_resp;
                    bus_rdata = cur_rdata;
                    drove = 1;
                    bus_active = 0;
                    resp_due = 1;
                end else if (bus_w >= TIMEOUT) begin
                    bus_active = 0;
                    resp_due = 1;
                end
            end
            if (!drove && noise_en && ($urandom % 3 == 0)) begin
                if (in_wait) begin
                    if (cur.wr) bus_rdone = 1'b1;
                    else bus_bdone = 1'b1;
                end else if ($urandom % 2 == 0) begin
                    bus_bdone = 1'b1;
                end else begin
                    bus_rdone = 1'b1;
                end
            end
        end
    end

    // Completion monitor: pops the scoreboard on every handshake.
    always @(negedge ACLK) begin
        rsp_t e;
        if (!ARESETN) begin
            have_prev = 0;
            hold = 0;
            rsp_ready = 1'b0;
        end else begin
            if (have_prev) begin
                chk("rsp_valid_held", rsp_valid, 1'b1);
                chk("rsp_write_stable", rsp_write, prev.wr);
                chk("rsp_data_stable", rsp_data, prev.data);
                chk("rsp_resp_stable", rsp_resp, prev.resp);
            end
            if (rsp_valid && !have_prev && hold_req > 0) begin
                hold = hold_req;
                hold_req = 0;
            end
            if (hold > 0) begin
                rsp_ready = 1'b0;
                hold--;
            end else if ($urandom % 8 == 0) begin
                rsp_ready = 1'b0;
                hold = int'($urandom_range(0, 9));
            end else begin
                rsp_ready = 1'b1;
            end
            if (rsp_valid) begin
                chk("busy_in_resp", busy, 1'b1);
                if (rsp_ready) begin
                    chk("rsp_expected", (rsp_q.size() != 0), 1'b1);
                    if (rsp_q.size() != 0) begin
                        e = rsp_q.pop_front();
                        chk("rsp_write", rsp_write, e.wr);
                        chk("rsp_data", rsp_data, e.data);
                        chk("rsp_resp", rsp_resp, e.resp);
                        $display("rsp: write=%0d data=0x%08h resp=%0d", rsp_write, rsp_data, rsp_resp);
                    end
                    have_prev = 0;
                end else begin
                    have_prev = 1;
                    prev.wr = rsp_write;
                    prev.data = rsp_data;
                    prev.resp = rsp_resp;
                end
            end else begin
                have_prev = 0;
            end
        end
    end

    task automatic send(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cmd_t c;
        int n;
        c.wr = wr;
        c.addr = a;
        c.data = d;
        n = 0;
        @(negedge ACLK);
        #2;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr = a;
        cmd_wdata = d;
        while (!cmd_ready && n < 200) begin
            @(negedge ACLK);
            #2;
            n++;
        end
        chk("cmd_accepted", cmd_ready, 1'b1);
        if (cmd_ready) begin
            cmd_q.push_back(c);
            $display("cmd: write=%0d addr=0x%08h wdata=0x%08h", wr, a, d);
        end
    endtask

    task automatic idle_cmd();
        @(negedge ACLK);
        #2;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit done;
        done = 0;
        for (int i = 0; i < 600 && !done; i++) begin
            @(negedge ACLK);
            #2;
            done = (cmd_q.size() == 0) && (rsp_q.size() == 0) && !bus_active && !rsp_valid && !busy;
        end
        chk("drain_done", done, 1'b1);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_read_s"}, read_s, 1'b0);
        chk({tag, "_write_s"}, write_s, 1'b0);
        chk({tag, "_rsp_valid"}, rsp_valid, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_rsp_write"}, rsp_write, 1'b0);
        chk({tag, "_rsp_resp"}, rsp_resp, 2'b00);
        chk({tag, "_rsp_data"}, rsp_data, '0);
        chk({tag, "_address"}, address, '0);
        chk({tag, "_W_data"}, W_data, '0);
    endtask

    initial begin
        int starts;
        int rvs;
        bit hit;
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        chk_outputs_zero("reset");
        #3 ARESETN = 1'b1;
        @(negedge ACLK);
        #2;
        chk("ready_after_reset", cmd_ready, 1'b1);

        // Directed write, done four cycles after write_s.
        dir_k = 4; dir_en = 1; dir_resp = 2'b00; dir_rdata = 32'hFFFF_FFFF;
        send(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
        idle_cmd();
        wait_drain();

        // Directed read.
        dir_k = 3; dir_en = 1; dir_resp = 2'b00; dir_rdata = 32'h1234_5678;
        send(1'b0, 32'h0000_0004, 32'h0);
        idle_cmd();
        wait_drain();

        // Read that never completes: forced timeout.
        dir_k = 0;
        send(1'b0, 32'h0000_0008, 32'h0);
        idle_cmd();
        wait_drain();

        // Consumer stalls 10 cycles with another command queued behind.
        dir_k = 2; hold_req = 10;
        send(1'b1, 32'h0000_0020, 32'hCAFE_F00D);
        send(1'b0, 32'h0000_0024, 32'h0);
        idle_cmd();
        wait_drain();

        // Fill: first command stalls in WAIT, four more fill the FIFO.
        dir_k = 0;
        for (int i = 0; i < 5; i++) begin
            send(i[0], 32'h100 + 32'(i * 4), 32'hA000_0000 + 32'(i));
        end
        @(negedge ACLK);
        #2;
        chk("full_after_5", cmd_ready, 1'b0);
        cmd_valid = 1'b1;
        send(1'b1, 32'h0000_0200, 32'h5555_AAAA);
        idle_cmd();
        wait_drain();

        // Randomized traffic.
        for (int i = 0; i < 60; i++) begin
            send(1'($urandom), $urandom, $urandom);
            if ($urandom % 3 == 0) begin
                idle_cmd();
                repeat ($urandom_range(0, 6)) @(negedge ACLK);
            end
        end
        idle_cmd();
        wait_drain();

        // Reset during WAIT with two commands queued.
        dir_k = 0;
        send(1'b0, 32'h0000_0300, 32'h0);
        send(1'b1, 32'h0000_0304, 32'h1111_2222);
        send(1'b0, 32'h0000_0308, 32'h0);
        idle_cmd();
        hit = 0;
        for (int i = 0; i < 50 && !hit; i++) begin
            @(negedge ACLK);
            hit = bus_active && (bus_w >= 2);
        end
        chk("reached_wait_before_reset", busy & hit, 1'b1);
        #3;
        ARESETN = 1'b0;
        cmd_q.delete();
        rsp_q.delete();
        bus_active = 0;
        resp_due = 0;
        #1;
        chk_outputs_zero("async_reset");
        repeat (3) @(negedge ACLK);
        #3 ARESETN = 1'b1;
        starts = 0;
        rvs = 0;
        repeat (20) begin
            @(negedge ACLK);
            if (read_s || write_s) starts++;
            if (rsp_valid) rvs++;
        end
        chk("post_reset_starts", starts, 0);
        chk("post_reset_rsp_valid", rvs, 0);
        chk("post_reset_ready", cmd_ready, 1'b1);

        // Normal operation resumes.
        send(1'b0, 32'h0000_0400, 32'h0);
        send(1'b1, 32'h0000_0404, 32'h7777_8888);
        idle_cmd();
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
